// File: rtl/v7_pulse_generator.sv
// v7_pulse_generator: synthetic detector-pulse source for the variant-7
// shaping filter; linear rise then shift-based exponential decay.
`timescale 1ns/1ps
module v7_pulse_generator #(
   parameter int SIZE_ADC_DATA = 14,
   parameter int RISE_SHIFT    = 2,
   parameter int DECAY_SHIFT   = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic                     abort,
   input  logic [SIZE_ADC_DATA-1:0] amplitude,
   input  logic [SIZE_ADC_DATA-1:0] baseline,
   output logic [SIZE_ADC_DATA-1:0] adc_data,
   output logic                     busy,
   output logic                     done,
   output logic [15:0]              pulse_count
);

   localparam int W  = SIZE_ADC_DATA;
   localparam int CW = RISE_SHIFT + 1;

   // last rise count before the peak sample (R-1)
   localparam logic [CW-1:0] CNT_LAST = CW'((1 << RISE_SHIFT) - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      IDLE,
      RISE,
      DECAY
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [W-1:0]  e;
   logic [W-1:0]  e_nx;
   logic [W-1:0]  amp;
   logic [W-1:0]  amp_nx;
   logic [W-1:0]  step;
   logic [W-1:0]  step_nx;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nx;
   logic [15:0]   count_q;
   logic [15:0]   count_nx;
   logic          done_nx;
   logic [W-1:0]  d;
   logic [W:0]    sum;
   logic [W-1:0]  adc_nx;
   logic          start_ok;

   assign d        = e >> DECAY_SHIFT;
   assign start_ok = start && !abort;

   // next-state and next-excursion decode for the pulse shape
   always_comb begin
      state_nx = state;
      e_nx     = e;
      amp_nx   = amp;
      step_nx  = step;
      cnt_nx   = cnt;
      count_nx = count_q;
      done_nx  = 1'b0;
      unique case (state)
         IDLE: begin
            e_nx = '0;
            if (start_ok) begin
               amp_nx  = amplitude;
               step_nx = amplitude >> RISE_SHIFT;
               if (RISE_SHIFT == 0) begin
                  e_nx     = amplitude;
                  state_nx = DECAY;
               end else begin
                  e_nx     = amplitude >> RISE_SHIFT;
                  cnt_nx   = CNT_ONE;
                  state_nx = RISE;
               end
            end
         end
         RISE: begin
            if (abort) begin
               e_nx     = '0;
               state_nx = IDLE;
            end else if (cnt == CNT_LAST) begin
               e_nx     = amp;
               state_nx = DECAY;
            end else begin
               e_nx   = e + step;
               cnt_nx = cnt + CNT_ONE;
            end
         end
         DECAY: begin
            if (abort) begin
               e_nx     = '0;
               state_nx = IDLE;
            end else if (d == '0) begin
               e_nx     = '0;
               state_nx = IDLE;
               done_nx  = 1'b1;
               count_nx = count_q + 16'd1;
            end else begin
               e_nx = e - d;
            end
         end
         default: begin
            e_nx     = '0;
            state_nx = IDLE;
         end
      endcase
   end

   // baseline plus excursion, clamped to the top code of the ADC bus
   always_comb begin
      sum    = {1'b0, baseline} + {1'b0, e_nx};
      adc_nx = sum[W] ? {W{1'b1}} : sum[W-1:0];
   end

   // all state and registered outputs, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         e        <= '0;
         amp      <= '0;
         step     <= '0;
         cnt      <= '0;
         count_q  <= '0;
         adc_data <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_nx;
         e        <= e_nx;
         amp      <= amp_nx;
         step     <= step_nx;
         cnt      <= cnt_nx;
         count_q  <= count_nx;
         adc_data <= adc_nx;
         busy     <= (state_nx != IDLE);
         done     <= done_nx;
      end
   end

   assign pulse_count = count_q;

endmodule

// File: tb/tb_v7_pulse_generator.sv
// tb_v7_pulse_generator: random and directed stimulus against a
// queue-based waveform model of the pulse generator.
`timescale 1ns/1ps
module tb_v7_pulse_generator;

   localparam int W    = 14;
   localparam int RS   = 2;
   localparam int DS   = 4;
   localparam int R    = 1 << RS;
   localparam int MAXV = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic [W-1:0] amplitude = '0;
   logic [W-1:0] baseline = '0;
   logic [W-1:0] adc_data;
   logic         busy;
   logic         done;
   logic [15:0]  pulse_count;

   int checks = 0;
   int failures = 0;

   int q_e[$];
   int m_adc = 0;
   int m_busy = 0;
   int m_done = 0;
   int m_count = 0;

   v7_pulse_generator #(
      .SIZE_ADC_DATA(W),
      .RISE_SHIFT(RS),
      .DECAY_SHIFT(DS)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .abort(abort),
      .amplitude(amplitude),
      .baseline(baseline),
      .adc_data(adc_data),
      .busy(busy),
      .done(done),
      .pulse_count(pulse_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t",
                  name, act, exp, $time);
      end
   endtask

   // whole excursion sequence of one pulse; last entry is the done sample
   function automatic void build(input int a);
      int x;
      q_e.delete();
      for (int k = 1; k < R; k++) q_e.push_back(k * (a >> RS));
      q_e.push_back(a);
      x = a;
      while ((x >> DS) != 0) begin
         x = x - (x >> DS);
         q_e.push_back(x);
      end
      q_e.push_back(0);
   endfunction

   // model step on each edge, then compare just after the edge
   always @(posedge clk) begin
      int e;
      e = 0;
      m_done = 0;
      if (!reset) begin
         q_e.delete();
         m_count = 0;
         m_adc = 0;
         m_busy = 0;
      end else begin
         if (q_e.size() != 0) begin
            if (abort) q_e.delete();
            else begin
               e = q_e.pop_front();
               if (q_e.size() == 0) begin
                  m_done = 1;
                  m_count = (m_count + 1) % 65536;
               end
            end
         end else if (start && !abort) begin
            build(int'(amplitude));
            e = q_e.pop_front();
         end
         m_busy = (q_e.size() != 0) ? 1 : 0;
         m_adc = int'(baseline) + e;
         if (m_adc > MAXV) m_adc = MAXV;
      end
      #1;
      chk("model_adc", int'(adc_data), m_adc);
      chk("model_busy", int'(busy), m_busy);
      chk("model_done", int'(done), m_done);
      chk("model_count", int'(pulse_count), m_count);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_done(input int max, output int n);
      n = 0;
      while (1) begin
         tick();
         n++;
         if (done) break;
         if (n >= max) begin
            chk("done_timeout", 0, 1);
            break;
         end
      end
   endtask

   initial begin
      int n;
      int c0;
      int exp_basic[7];
      exp_basic = '{356, 612, 868, 1124, 1060, 1000, 944};

      // reset with idle baseline
      baseline = 14'd512;
      tick();
      chk("rst_adc", int'(adc_data), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_count", int'(pulse_count), 0);
      reset = 1'b1;
      tick();
      chk("rel_adc", int'(adc_data), 512);

      // basic pulse
      baseline = 14'd100;
      amplitude = 14'd1024;
      start = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         start = 1'b0;
         chk($sformatf("basic_%0d", i), int'(adc_data), exp_basic[i]);
      end
      wait_done(300, n);
      chk("basic_done_adc", int'(adc_data), 100);
      chk("basic_done_busy", int'(busy), 0);
      chk("basic_count", int'(pulse_count), 1);
      tick();
      chk("basic_done_once", int'(done), 0);

      // saturation
      baseline = 14'd16000;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("sat_rise0", int'(adc_data), 16256);
      tick();
      chk("sat_rise1", int'(adc_data), 16383);
      tick();
      tick();
      chk("sat_peak", int'(adc_data), 16383);
      wait_done(300, n);
      chk("sat_done_adc", int'(adc_data), 16000);

      // handshake: start held through two pulses
      baseline = 14'd200;
      amplitude = 14'd64;
      c0 = int'(pulse_count);
      start = 1'b1;
      wait_done(300, n);
      tick();
      chk("b2b_busy", int'(busy), 1);
      chk("b2b_count1", int'(pulse_count), (c0 + 1) % 65536);
      wait_done(300, n);
      start = 1'b0;
      chk("b2b_count2", int'(pulse_count), (c0 + 2) % 65536);
      tick();
      tick();

      // abort mid-decay
      baseline = 14'd300;
      amplitude = 14'd2000;
      c0 = int'(pulse_count);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_adc", int'(adc_data), 300);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_count", int'(pulse_count), c0);
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      chk("abort_blocks_start", int'(busy), 0);

      // zero amplitude
      baseline = 14'd50;
      amplitude = 14'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("zero_adc", int'(adc_data), 50);
      wait_done(50, n);
      chk("zero_len", n + 1, R + 1);

      // reset mid-rise
      amplitude = 14'd1000;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      reset = 1'b0;
      tick();
      chk("midrst_adc", int'(adc_data), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_count", int'(pulse_count), 0);
      reset = 1'b1;
      tick();

      // counter wrap
      force dut.count_q = 16'hFFFF;
      m_count = 65535;
      tick();
      release dut.count_q;
      tick();
      chk("wrap_pre", int'(pulse_count), 65535);
      amplitude = 14'd0;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done(50, n);
      chk("wrap_count", int'(pulse_count), 0);

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         start = ($urandom_range(0, 3) == 0);
         abort = ($urandom_range(0, 79) == 0);
         if ($urandom_range(0, 3) == 0)
            amplitude = W'($urandom_range(0, 40));
         else
            amplitude = W'($urandom_range(0, MAXV));
         if ($urandom_range(0, 49) == 0)
            baseline = W'($urandom_range(0, MAXV));
         reset = ($urandom_range(0, 999) != 0);
         tick();
      end
      start = 1'b0;
      abort = 1'b0;
      reset = 1'b1;
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
